// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared widths, types and PC field helpers for the BTB update path
package btb_pkg;

  localparam int BTB_ADDR_W  = 32;
  localparam int BTB_SETS    = 8;
  localparam int BTB_INDEX_W = $clog2(BTB_SETS);
  localparam int BTB_TAG_W   = BTB_ADDR_W - BTB_INDEX_W - 2;

  localparam logic [1:0] CTR_ALLOC = 2'b10;

  typedef struct packed {
    logic [BTB_ADDR_W-1:0] pc;
    logic [BTB_ADDR_W-1:0] target;
    logic                  taken;
  } btb_upd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DECIDE,
    WRITE
  } btb_state_e;

  function automatic logic [BTB_INDEX_W-1:0] pc_index(input logic [BTB_ADDR_W-1:0] pc);
    return BTB_INDEX_W'(pc >> 2);
  endfunction

  function automatic logic [BTB_TAG_W-1:0] pc_tag(input logic [BTB_ADDR_W-1:0] pc);
    return BTB_TAG_W'(pc >> (BTB_INDEX_W + 2));
  endfunction

  // Saturating 2-bit direction counter step
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/btb_update_ctrl_fifo.sv
// rtl/btb_update_ctrl_fifo.sv - pending-update FIFO of resolved branches (btb_upd_fifo)
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  btb_upd_t push_data,
  input  logic     pop,
  output btb_upd_t head,
  output logic     full,
  output logic     empty
);

  localparam int             PTR_W   = $clog2(QDEPTH);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(QDEPTH);

  btb_upd_t         mem_q [QDEPTH];
  btb_upd_t         mem_d [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_MAX);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when a pop happens in the same cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write-side controller: queue, lookup, decide, write and LRU update
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter  int ADDR_W  = BTB_ADDR_W,
  parameter  int SETS    = BTB_SETS,
  parameter  int QDEPTH  = 2,
  localparam int INDEX_W = $clog2(SETS),
  localparam int TAG_W   = ADDR_W - INDEX_W - 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [ADDR_W-1:0]  ex_pc,
  input  logic [ADDR_W-1:0]  ex_target,
  input  logic               ex_taken,
  output logic               arr_rd_en,
  output logic [INDEX_W-1:0] arr_rd_idx,
  input  logic [1:0]         arr_rd_vld,
  input  logic [TAG_W-1:0]   arr_rd_tag0,
  input  logic [TAG_W-1:0]   arr_rd_tag1,
  input  logic [1:0]         arr_rd_ctr0,
  input  logic [1:0]         arr_rd_ctr1,
  input  logic               lru_bit,
  output logic               arr_we,
  output logic [INDEX_W-1:0] arr_wr_idx,
  output logic               arr_wr_way,
  output logic [TAG_W-1:0]   arr_wr_tag,
  output logic [ADDR_W-1:0]  arr_wr_target,
  output logic [1:0]         arr_wr_ctr,
  output logic               update,
  output logic [INDEX_W-1:0] update_index,
  output logic               update_lru_write
);

  btb_state_e         state_q, state_d;
  btb_upd_t           op_q, op_d;
  btb_upd_t           ex_upd, fifo_head, next_op;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic               more_work, go_lookup;

  logic               rd_en_q, rd_en_d;
  logic [INDEX_W-1:0] rd_idx_q, rd_idx_d;
  logic               we_q, we_d;
  logic [INDEX_W-1:0] wr_idx_q, wr_idx_d;
  logic               wr_way_q, wr_way_d;
  logic [TAG_W-1:0]   wr_tag_q, wr_tag_d;
  logic [ADDR_W-1:0]  wr_target_q, wr_target_d;
  logic [1:0]         wr_ctr_q, wr_ctr_d;

  logic [TAG_W-1:0]   op_tag;
  logic               hit0, hit1, need_write, dec_way;
  logic [1:0]         dec_ctr;

  assign ex_upd    = '{pc: ex_pc, target: ex_target, taken: ex_taken};
  assign ex_ready  = !fifo_full;
  assign fifo_push = ex_valid && !fifo_full;
  assign fifo_pop  = (state_q == LOOKUP);
  // A push in this cycle counts as pending work so an idle block reaches LOOKUP on the next edge
  assign more_work = !fifo_empty || fifo_push;
  assign next_op   = fifo_empty ? ex_upd : fifo_head;

  btb_upd_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(ex_upd),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign op_tag     = pc_tag(op_q.pc);
  assign hit0       = arr_rd_vld[0] && (arr_rd_tag0 == op_tag);
  assign hit1       = arr_rd_vld[1] && (arr_rd_tag1 == op_tag);
  assign need_write = hit0 || hit1 || op_q.taken;

  always_comb begin
    dec_way = 1'b0;
    dec_ctr = CTR_ALLOC;
    if (hit0) begin
      dec_way = 1'b0;
      dec_ctr = ctr_next(arr_rd_ctr0, op_q.taken);
    end else if (hit1) begin
      dec_way = 1'b1;
      dec_ctr = ctr_next(arr_rd_ctr1, op_q.taken);
    end else if (!arr_rd_vld[0]) begin
      dec_way = 1'b0;
    end else if (!arr_rd_vld[1]) begin
      dec_way = 1'b1;
    end else begin
      dec_way = ~lru_bit;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    go_lookup   = 1'b0;
    rd_en_d     = 1'b0;
    rd_idx_d    = '0;
    we_d        = 1'b0;
    wr_idx_d    = '0;
    wr_way_d    = 1'b0;
    wr_tag_d    = '0;
    wr_target_d = '0;
    wr_ctr_d    = '0;
    case (state_q)
      IDLE: begin
        go_lookup = more_work;
      end
      LOOKUP: begin
        state_d = DECIDE;
      end
      DECIDE: begin
        if (need_write) begin
          state_d     = WRITE;
          we_d        = 1'b1;
          wr_idx_d    = pc_index(op_q.pc);
          wr_way_d    = dec_way;
          wr_tag_d    = op_tag;
          wr_target_d = op_q.target;
          wr_ctr_d    = dec_ctr;
        end else if (more_work) begin
          go_lookup = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (more_work) begin
          go_lookup = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_lookup) begin
      state_d  = LOOKUP;
      op_d     = next_op;
      rd_en_d  = 1'b1;
      rd_idx_d = pc_index(next_op.pc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rd_en_q     <= 1'b0;
      rd_idx_q    <= '0;
      we_q        <= 1'b0;
      wr_idx_q    <= '0;
      wr_way_q    <= 1'b0;
      wr_tag_q    <= '0;
      wr_target_q <= '0;
      wr_ctr_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_en_q     <= rd_en_d;
      rd_idx_q    <= rd_idx_d;
      we_q        <= we_d;
      wr_idx_q    <= wr_idx_d;
      wr_way_q    <= wr_way_d;
      wr_tag_q    <= wr_tag_d;
      wr_target_q <= wr_target_d;
      wr_ctr_q    <= wr_ctr_d;
    end
  end

  assign arr_rd_en        = rd_en_q;
  assign arr_rd_idx       = rd_idx_q;
  assign arr_we           = we_q;
  assign arr_wr_idx       = wr_idx_q;
  assign arr_wr_way       = wr_way_q;
  assign arr_wr_tag       = wr_tag_q;
  assign arr_wr_target    = wr_target_q;
  assign arr_wr_ctr       = wr_ctr_q;
  // The written way becomes MRU
  assign update           = we_q;
  assign update_index     = wr_idx_q;
  assign update_lru_write = wr_way_q;

endmodule
